mem_access_stage: RTL and testbench

Pipeline MEM stage of the LEGv8 core. Consumes the EX/MEM register outputs (`*_s4`), performs the data-memory load/store against an internal doubleword RAM with configurable access latency, and resolves the branch decision. Results are registered into the MEM/WB fields (`*_s5`). The stage raises `Stall` while a multi-cycle access is in flight.

---
 rtl/mem_access_stage.sv | 139 +++++++++++++
 tb/tb_mem_access_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: data-memory load/store on an internal doubleword RAM, branch resolve, MEM/WB register.
// Latency: LATENCY cycles for memory ops, 1 cycle otherwise.
// Backpressure: Stall holds upstream while a multi-cycle access is in flight; bubbles go to MEM/WB.
module mem_access_stage #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RegWrite_s4,
    input  logic        MemtoReg_s4,
    input  logic        Branch_s4,
    input  logic        MemRead_s4,
    input  logic        MemWrite_s4,
    input  logic [63:0] BranchAdder_s4,
    input  logic        Zero_s4,
    input  logic [63:0] ALUResult_s4,
    input  logic [63:0] RD2_s4,
    input  logic [4:0]  WR_s4,
    output logic        PCSrc,
    output logic [63:0] BranchTarget,
    output logic        Stall,
    output logic        RegWrite_s5,
    output logic        MemtoReg_s5,
    output logic [63:0] ReadData_s5,
    output logic [63:0] ALUResult_s5,
    output logic [4:0]  WR_s5,
    output logic        MisalignErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 2) ? LATENCY - 2 : 0);
    localparam bit MULTI = (LATENCY > 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mem_access_stage: DEPTH must be a power of 2 and at least 2");
        end
        if (LATENCY < 1) begin : g_bad_latency
            $error("mem_access_stage: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_op;
    logic            misaligned;
    logic            stall;
    logic            complete;
    logic            do_store;
    logic [AW-1:0]   idx;
    logic [63:0]     load_data;

    logic [63:0] mem [DEPTH];

    assign mem_op     = MemRead_s4 | MemWrite_s4;
    assign misaligned = (ALUResult_s4[2:0] != 3'b000);
    // Upper address bits are dropped so addresses wrap modulo DEPTH*8.
    assign idx        = ALUResult_s4[AW+2:3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && MULTI) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    stall = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every non-stalled edge retires the instruction currently presented.
    assign complete  = ~stall;
    assign do_store  = complete & MemWrite_s4 & ~misaligned;
    assign load_data = misaligned ? 64'd0 : mem[idx];

    always_ff @(posedge clock) begin
        if (do_store && !reset) begin
            mem[idx] <= RD2_s4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite_s5  <= 1'b0;
            MemtoReg_s5  <= 1'b0;
            ReadData_s5  <= '0;
            ALUResult_s5 <= '0;
            WR_s5        <= '0;
            MisalignErr  <= 1'b0;
        end else if (complete) begin
            RegWrite_s5  <= RegWrite_s4;
            MemtoReg_s5  <= MemtoReg_s4;
            ReadData_s5  <= MemRead_s4 ? load_data : 64'd0;
            ALUResult_s5 <= ALUResult_s4;
            WR_s5        <= WR_s4;
            if (mem_op && misaligned) begin
                MisalignErr <= 1'b1;
            end
        end else begin
            RegWrite_s5 <= 1'b0;
            MemtoReg_s5 <= 1'b0;
        end
    end

    assign Stall        = stall;
    assign PCSrc        = Branch_s4 & Zero_s4 & ~stall;
    assign BranchTarget = BranchAdder_s4;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (LATENCY 2, 4, 1), directed table plus random ops.
// Latency: n/a.
// Backpressure: inputs are held for the whole Stall window of each op.
module tb_mem_access_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        br;
        logic        zero;
        logic        mr;
        logic        mw;
        logic [63:0] badd;
        logic [63:0] alu;
        logic [63:0] rd2;
        logic [4:0]  wr;
    } in_t;

    typedef struct packed {
        logic        pcsrc;
        logic [63:0] btgt;
        logic        stall;
        logic        rw5;
        logic        m2r5;
        logic [63:0] rd5;
        logic [63:0] alu5;
        logic [4:0]  wr5;
        logic        merr;
    } out_t;

    typedef struct {
        string       nm;
        in_t         v;
        logic        pc;
        logic [63:0] rd;
        logic        merr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  in_v  [3];
    logic rst_v [3];

    int checks   = 0;
    int failures = 0;

    // Reference model: per-instance memory image, sticky error flag, last retired MEM/WB values.
    logic [63:0] mm [3][64];
    bit          mv [3][64];
    bit          merr_m [3];
    logic [63:0] pa [3];
    logic [63:0] pr [3];
    bit          pk [3];
    logic [4:0]  pw [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
            in_t         iv;
            out_t        o;
            logic        pcsrc, stall, rw5, m2r5, merr;
            logic [63:0] btgt, rd5, alu5;
            logic [4:0]  wr5;
            assign iv = in_v[g];
            mem_access_stage #(.DEPTH(64), .LATENCY(LAT)) u_dut (
                .clock          (clk),
                .reset          (rst_v[g]),
                .RegWrite_s4    (iv.rw),
                .MemtoReg_s4    (iv.m2r),
                .Branch_s4      (iv.br),
                .MemRead_s4     (iv.mr),
                .MemWrite_s4    (iv.mw),
                .BranchAdder_s4 (iv.badd),
                .Zero_s4        (iv.zero),
                .ALUResult_s4   (iv.alu),
                .RD2_s4         (iv.rd2),
                .WR_s4          (iv.wr),
                .PCSrc          (pcsrc),
                .BranchTarget   (btgt),
                .Stall          (stall),
                .RegWrite_s5    (rw5),
                .MemtoReg_s5    (m2r5),
                .ReadData_s5    (rd5),
                .ALUResult_s5   (alu5),
                .WR_s5          (wr5),
                .MisalignErr    (merr)
            );
            assign o = {pcsrc, btgt, stall, rw5, m2r5, rd5, alu5, wr5, merr};
        end
    endgenerate

    function automatic out_t get(input int s);
        case (s)
            0:       get = g_dut[0].o;
            1:       get = g_dut[1].o;
            default: get = g_dut[2].o;
        endcase
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 4 : 1);
    endfunction

    function automatic in_t mk(input bit rw, input bit m2r, input bit br, input bit z,
                               input bit mr, input bit mw, input logic [63:0] badd,
                               input logic [63:0] alu, input logic [63:0] rd2, input logic [4:0] wr);
        in_t v;
        v.rw = rw; v.m2r = m2r; v.br = br; v.zero = z; v.mr = mr; v.mw = mw;
        v.badd = badd; v.alu = alu; v.rd2 = rd2; v.wr = wr;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int s);
        out_t o;
        in_v[s]  = '0;
        rst_v[s] = 1'b1;
        #1;
        o = get(s);
        check("rst_rw5", o.rw5, 0);
        check("rst_m2r5", o.m2r5, 0);
        check("rst_rd5", o.rd5, 0);
        check("rst_alu5", o.alu5, 0);
        check("rst_wr5", o.wr5, 0);
        check("rst_merr", o.merr, 0);
        check("rst_stall", o.stall, 0);
        check("rst_pcsrc", o.pcsrc, 0);
        @(posedge clk); #1;
        rst_v[s]  = 1'b0;
        merr_m[s] = 1'b0;
        pa[s] = '0; pr[s] = '0; pk[s] = 1'b1; pw[s] = '0;
    endtask

    // Presents one instruction, checks the stall window and bubbles, then the retired MEM/WB values.
    task automatic run_op(input int s, input in_t v, output logic pc0, output logic [63:0] rd_out);
        out_t        o;
        int          ncyc, idx;
        bit          memop, mis, known;
        logic [63:0] exp_rd;
        memop = v.mr | v.mw;
        ncyc  = (memop && lat_of(s) > 1) ? lat_of(s) - 1 : 0;
        in_v[s] = v;
        #1;
        o   = get(s);
        pc0 = o.pcsrc;
        check("btgt", o.btgt, v.badd);
        for (int k = 0; k < ncyc; k++) begin
            o = get(s);
            check("stall_hi", o.stall, 1);
            check("pcsrc_stall", o.pcsrc, 0);
            @(posedge clk); #1;
            o = get(s);
            check("bub_rw5", o.rw5, 0);
            check("bub_m2r5", o.m2r5, 0);
            check("hold_alu5", o.alu5, pa[s]);
            check("hold_wr5", o.wr5, pw[s]);
            if (pk[s]) check("hold_rd5", o.rd5, pr[s]);
        end
        o = get(s);
        check("stall_lo", o.stall, 0);
        check("pcsrc", o.pcsrc, v.br & v.zero);

        mis = (v.alu % 8) != 0;
        idx = int'((v.alu / 8) % 64);
        if (!v.mr) begin
            exp_rd = '0; known = 1'b1;
        end else if (mis) begin
            exp_rd = '0; known = 1'b1;
        end else begin
            exp_rd = mm[s][idx]; known = mv[s][idx];
        end
        if (v.mw && !mis) begin
            mm[s][idx] = v.rd2;
            mv[s][idx] = 1'b1;
        end
        if (memop && mis) merr_m[s] = 1'b1;

        @(posedge clk); #1;
        o = get(s);
        check("rw5", o.rw5, v.rw);
        check("m2r5", o.m2r5, v.m2r);
        check("alu5", o.alu5, v.alu);
        check("wr5", o.wr5, v.wr);
        if (known) check("rd5", o.rd5, exp_rd);
        check("merr", o.merr, merr_m[s]);
        pa[s] = v.alu; pw[s] = v.wr; pr[s] = exp_rd; pk[s] = known;
        rd_out = o.rd5;
    endtask

    task automatic random_phase(input int s, input int n);
        in_t         v;
        logic        pc;
        logic [63:0] rd;
        int          t;
        for (int i = 0; i < 64; i++) begin
            v = '0;
            v.mw  = 1'b1;
            v.alu = 64'(i * 8) + (64'($urandom_range(0, 7)) << 9);
            v.rd2 = {$urandom(), $urandom()};
            v.wr  = 5'($urandom());
            run_op(s, v, pc, rd);
        end
        for (int i = 0; i < n; i++) begin
            t      = $urandom_range(0, 3);
            v.rw   = 1'($urandom());
            v.m2r  = 1'($urandom());
            v.br   = 1'($urandom());
            v.zero = 1'($urandom());
            v.mr   = (t == 1 || t == 3);
            v.mw   = (t >= 2);
            v.badd = {$urandom(), $urandom()};
            v.alu  = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) != 0) v.alu[2:0] = 3'b000;
            v.rd2  = {$urandom(), $urandom()};
            v.wr   = 5'($urandom());
            run_op(s, v, pc, rd);
        end
    endtask

    task automatic add_vec(input string nm, input in_t v, input logic pc, input logic [63:0] rd, input logic merr,
                           inout vec_t q[$]);
        vec_t r;
        r.nm = nm; r.v = v; r.pc = pc; r.rd = rd; r.merr = merr;
        q.push_back(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic        pc;
        logic [63:0] rd;
        out_t        o;
        in_t         v;

        for (int s = 0; s < 3; s++) begin
            in_v[s]  = '0;
            rst_v[s] = 1'b1;
        end
        #2;
        for (int s = 0; s < 3; s++) do_reset(s);

        //            name        rw m2r br z mr mw badd    alu       rd2                   wr     pc  rd                     merr
        add_vec("st_10",   mk(0, 0, 0, 0, 0, 1, 64'h0,  64'h10,  64'h1122334455667788, 5'd0), 0, 64'h0,                 0, tbl);
        add_vec("ld_10",   mk(1, 1, 0, 0, 1, 0, 64'h0,  64'h10,  64'h0,                5'd5), 0, 64'h1122334455667788, 0, tbl);
        add_vec("st_13",   mk(0, 0, 0, 0, 0, 1, 64'h0,  64'h13,  64'hFFFFFFFFFFFFFFFF, 5'd0), 0, 64'h0,                 1, tbl);
        add_vec("ld_10b",  mk(1, 1, 0, 0, 1, 0, 64'h0,  64'h10,  64'h0,                5'd7), 0, 64'h1122334455667788, 1, tbl);
        add_vec("br_tk",   mk(0, 0, 1, 1, 0, 0, 64'h40, 64'h0,   64'h0,                5'd0), 1, 64'h0,                 1, tbl);
        add_vec("br_nt",   mk(0, 0, 1, 0, 0, 0, 64'h40, 64'h0,   64'h0,                5'd0), 0, 64'h0,                 1, tbl);
        add_vec("add",     mk(1, 0, 0, 0, 0, 0, 64'h0,  64'hDEAD, 64'h0,               5'd3), 0, 64'h0,                 1, tbl);
        add_vec("st_200",  mk(0, 0, 0, 0, 0, 1, 64'h0,  64'h200, 64'hAA,               5'd0), 0, 64'h0,                 1, tbl);
        add_vec("ld_0",    mk(1, 1, 0, 0, 1, 0, 64'h0,  64'h0,   64'h0,                5'd9), 0, 64'hAA,                1, tbl);
        add_vec("br_ld",   mk(1, 1, 1, 1, 1, 0, 64'h80, 64'h10,  64'h0,                5'd2), 0, 64'h1122334455667788, 1, tbl);
        add_vec("rdwr_10", mk(1, 1, 0, 0, 1, 1, 64'h0,  64'h10,  64'h5555,             5'd4), 0, 64'h1122334455667788, 1, tbl);
        add_vec("ld_10c",  mk(1, 1, 0, 0, 1, 0, 64'h0,  64'h10,  64'h0,                5'd6), 0, 64'h5555,              1, tbl);

        foreach (tbl[i]) begin
            run_op(0, tbl[i].v, pc, rd);
            o = get(0);
            check({tbl[i].nm, "_pc"}, pc, tbl[i].pc);
            check({tbl[i].nm, "_rd"}, rd, tbl[i].rd);
            check({tbl[i].nm, "_merr"}, o.merr, tbl[i].merr);
        end

        // Reset in the middle of a LATENCY=4 store must abort it.
        run_op(1, mk(0, 0, 0, 0, 0, 1, 64'h0, 64'h8, 64'h55, 5'd0), pc, rd);
        v = mk(0, 0, 0, 0, 0, 1, 64'h0, 64'h8, 64'h99, 5'd1);
        in_v[1] = v;
        #1;
        o = get(1);
        check("abort_stall_c1", o.stall, 1);
        @(posedge clk); #1;
        o = get(1);
        check("abort_stall_c2", o.stall, 1);
        in_v[1]  = '0;
        rst_v[1] = 1'b1;
        #1;
        o = get(1);
        check("abort_alu5", o.alu5, 0);
        check("abort_rw5", o.rw5, 0);
        check("abort_idle", o.stall, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_v[1]  = 1'b0;
        merr_m[1] = 1'b0;
        pa[1] = '0; pr[1] = '0; pk[1] = 1'b1; pw[1] = '0;
        run_op(1, mk(1, 1, 0, 0, 1, 0, 64'h0, 64'h8, 64'h0, 5'd4), pc, rd);
        check("abort_ld8", rd, 64'h55);

        do_reset(0);
        random_phase(0, 150);
        do_reset(2);
        random_phase(2, 120);
        random_phase(1, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
